// File: rtl/message_printer_pkg.sv
// Shared types and constants for the message printer sequencer.
package message_printer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GUARD = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int GUARD_CYCLES = 1;
  localparam int GUARD_W      = 2;
  localparam int BYTE_W       = 8;

endpackage

// File: rtl/message_printer_if.sv
// ROM-side and UART-side handshake bundle of the message printer.
interface message_printer_if #(
  parameter int ADDR_W = 4
);

  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_new;
  logic              tx_busy;
  logic              busy;
  logic              done;

  modport master (
    input  start, rom_data, tx_busy,
    output rom_addr, tx_data, tx_new, busy, done
  );

  modport slave (
    output start, rom_data, tx_busy,
    input  rom_addr, tx_data, tx_new, busy, done
  );

endinterface

// File: rtl/message_printer.sv
// Steps the message ROM address and hands each byte to the UART TX over a
// new/busy handshake; one message per start, or continuous when REPEAT = 1.
module message_printer
  import message_printer_pkg::*;
#(
  parameter int MSG_LEN = 16,
  parameter int ADDR_W  = 4,
  parameter int REPEAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  message_printer_if.master bus
);

  if ((MSG_LEN < 1) || (MSG_LEN > (1 << ADDR_W))) begin : g_len_check
    $error("message_printer: MSG_LEN out of range for ADDR_W");
  end

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(MSG_LEN - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_nxt_s;
  logic                tx_new_r, tx_new_nxt_s;
  logic                done_r, done_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic [GUARD_W-1:0]  guard_cnt_r, guard_cnt_nxt_s;

  // State and output registers; reset abandons any in-flight byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      tx_data_r   <= 8'h00;
      tx_new_r    <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      guard_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_new_r    <= tx_new_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
      guard_cnt_r <= guard_cnt_nxt_s;
    end
  end

  // Next-state, address stepping and handshake decisions.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    tx_data_nxt_s   = tx_data_r;
    tx_new_nxt_s    = 1'b0;
    done_nxt_s      = 1'b0;
    guard_cnt_nxt_s = guard_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          addr_nxt_s  = '0;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_nxt_s   = bus.rom_data;
          tx_new_nxt_s    = 1'b1;
          guard_cnt_nxt_s = '0;
          state_nxt_s     = ST_GUARD;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      // TX may only raise busy the cycle after tx_new, so it is not trusted here.
      ST_GUARD: begin
        if (guard_cnt_r == GUARD_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          guard_cnt_nxt_s = guard_cnt_r + GUARD_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!bus.tx_busy) begin
          if (addr_r == LAST_ADDR) begin
            done_nxt_s  = 1'b1;
            addr_nxt_s  = '0;
            state_nxt_s = (REPEAT != 0) ? ST_FETCH : ST_IDLE;
          end else begin
            addr_nxt_s  = addr_r + ADDR_W'(1);
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        addr_nxt_s  = '0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  assign bus.rom_addr = addr_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_new   = tx_new_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: doc/message_printer.md
Name: message_printer

Overview:
- Sequencer directly downstream of the 16-entry message ROM.
- Steps the ROM address, absorbs the ROM's one-cycle registered read latency, and hands each byte to the UART transmitter over a new/busy handshake.
- Sits between the message ROM and the UART TX in the hello-world top level. Sends one full message per start pulse, or repeats continuously when configured.

Parameters:
- MSG_LEN, 16, number of bytes per message; legal range 1..2**ADDR_W (elaboration check).
- ADDR_W, 4, ROM address width.
- REPEAT, 0, 0 = one message per start; 1 = restart automatically after the last byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request one message; sampled only in IDLE.
- rom_addr  out  ADDR_W  address to the message ROM.
- rom_data  in  8  ROM output, valid the cycle after rom_addr changes.
- tx_data  out  8  byte to the UART TX, registered.
- tx_new  out  1  one-cycle strobe: tx_data is valid.
- tx_busy  in  1  UART TX busy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte's transmission completes.

Behaviour:
- Reset (rst_n low at clk edge):
  - state = IDLE; addr = 0; tx_new = 0; tx_data = 0x00; done = 0; busy = 0.
  - Applies from any state. An in-flight byte is abandoned and no further tx_new is issued.
- rom_addr is driven directly from the addr register at all times.
- IDLE:
  - start = 1 at edge k: addr = 0, go to FETCH.
  - With REPEAT = 1, IDLE is still left only via start.
- FETCH (1 cycle): ROM latches addr. Go to SEND.
- SEND:
  - rom_data is valid. Wait while tx_busy = 1.
  - When tx_busy = 0: register tx_data = rom_data and tx_new = 1 for exactly one cycle, then go to GUARD.
- GUARD (1 cycle): tx_busy is ignored, which covers the TX raising busy one cycle after tx_new. Go to DRAIN.
- DRAIN: wait for tx_busy = 0.
  - If addr == MSG_LEN-1: pulse done for one cycle and set addr = 0. REPEAT = 0 → IDLE; REPEAT = 1 → FETCH.
  - Otherwise: addr = addr + 1 → FETCH.
- Latency:
  - start sampled at edge k with tx_busy = 0 → tx_new high during cycle k+3.
  - Minimum byte-to-byte spacing with an always-idle TX: 4 cycles (SEND, GUARD, DRAIN, FETCH).
- Boundaries:
  - start while busy = 1 is ignored, not queued.
  - addr never exceeds MSG_LEN-1 and never wraps by increment. It is cleared explicitly at message end.
  - tx_new and done are never high simultaneously.
  - With MSG_LEN = 1, each message is exactly one byte at addr 0.
  - tx_busy stuck at 1 stalls in SEND or DRAIN indefinitely; no timeout.
  - tx_data holds its last value when tx_new = 0.

Decomposition:
- Package message_printer_pkg:
  - state encoding IDLE/FETCH/SEND/GUARD/DRAIN (3 bits);
  - GUARD_CYCLES = 1 constant.
- No internal sub-module; single FSM plus address counter. The ROM is instantiated beside this block in the top level.
- Bench pairs the block with the real message ROM and a behavioural UART TX model.

Test Plan:
1. Reset then start pulse, REPEAT = 0, TX model busy for 10 cycles per byte → 16 tx_new strobes. Bytes are 0x48 'H', 0x65, 0x6C, 0x6C, 0x6F, 0x20, 0x0A, 0x0D, 0x57, 0x6F, 0x72, 0x6C, 0x64, 0x21, 0x0A, 0x0D. done pulses once after the last byte; busy then falls; addr = 0.
2. TX always idle, start at edge k → first tx_new in cycle k+3 with tx_data = 0x48; subsequent strobes exactly 4 cycles apart.
3. start re-pulsed mid-message (at byte 5) → ignored; still exactly 16 bytes in order and one done pulse.
4. rst_n low for 1 cycle while in DRAIN at addr 7 → next cycle state IDLE, tx_new = 0, busy = 0, rom_addr = 0. A new start sends from 'H'.
5. REPEAT = 1, one start → 48 bytes across three messages, with three done pulses spaced 16 strobes apart.
6. tx_busy held high for 100 cycles before the first byte → tx_new stays 0 throughout; tx_new is issued 1 cycle after busy drops, data 0x48.
